fwd_scoreboard: RTL
===================

FWD_SCOREBOARD -- requirements
Module: fwd_scoreboard

Interface
REQ-001 The block SHALL have parameter REG_W, default 5, giving the register-address width.
REQ-002 The block SHALL have parameter NUM_SRC, default 2, giving the source operands per instruction.
REQ-003 The block SHALL have parameter DEPTH, default 3, giving the tracked stages (stage 1 = EX, DEPTH = WB), with legal range 2..8.
REQ-004 The block SHALL have parameter LOAD_STAGE, default 3, giving the first stage whose load data is forwardable, with legal range 2..DEPTH.
REQ-005 The block SHALL have parameter SEL_W, equal to clog2(DEPTH+1) and not overridable.
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-low reset.
REQ-008 The block SHALL have port id_valid_i, input, 1 bit: an instruction is present in ID.
REQ-009 The block SHALL have port id_rs_i, input, NUM_SRC*REG_W bits: ID source addresses, with source s at bits [s*REG_W +: REG_W].
REQ-010 The block SHALL have port id_rd_i, input, REG_W bits: ID destination address.
REQ-011 The block SHALL have port id_rw_i, input, 1 bit: ID instruction writes rd.
REQ-012 The block SHALL have port id_load_i, input, 1 bit: ID instruction is a load.
REQ-013 The block SHALL have port flush_i, input, 1 bit: kill the ID instruction and the stage-1 entry.
REQ-014 The block SHALL have port fwd_sel_o, output, NUM_SRC*SEL_W bits: per-source forward select for the stage-1 instruction.
REQ-015 The block SHALL have port stall_o, output, 1 bit: load-use hazard; hold PC/IF/ID.
REQ-016 The block SHALL have port stall_cnt_o, output, 16 bits: saturating count of stall cycles.

Function
REQ-017 Each stage entry SHALL hold valid, rw, load, rd and NUM_SRC source addresses.
REQ-018 On each rising edge, entry k SHALL move to k+1 for k=1..DEPTH-1, and the entry in stage DEPTH SHALL retire.
REQ-019 On each rising edge, stage 1 SHALL load the ID instruction with valid=id_valid_i, unless stall_o or flush_i is high, in which case stage 1 SHALL load a bubble (valid=0).
REQ-020 A stage k is a producer for address a when valid=1, rw=1, rd!=0 and rd==a.
REQ-021 fwd_sel_o[s] SHALL equal DEPTH+1-k, where k is the smallest k in 2..DEPTH that is a producer for stage-1 source s; if no such k exists, fwd_sel_o[s] SHALL be 0.
REQ-022 With DEPTH=3, forwarding from MEM SHALL give select 2 and forwarding from WB SHALL give select 1, with the youngest producer winning.
REQ-023 fwd_sel_o SHALL be 0 for every source while stage 1 is invalid.
REQ-024 stall_o SHALL be high when id_valid_i=1, flush_i=0, and any ID source has a producer with load=1 in stages 1..LOAD_STAGE-2.
REQ-025 With LOAD_STAGE=2, stall_o SHALL be constant 0.
REQ-026 A stalled ID instruction SHALL re-evaluate every cycle, so a multi-cycle stall lasts until the load reaches stage LOAD_STAGE-1.
REQ-027 Source address 0 SHALL never forward and SHALL never stall.
REQ-028 When flush_i and a stall condition coincide, flush SHALL win: stall_o=0 and stage 1 loads a bubble.
REQ-029 stall_cnt_o SHALL increment by 1 per cycle with stall_o=1 and SHALL saturate at 16'hFFFF.
REQ-030 fwd_sel_o and stall_o SHALL be combinational from registered state and current ID inputs, with no added latency.

Reset
REQ-031 While rst_i=0, all stage valid bits SHALL be 0 and stall_cnt_o SHALL be 0, so fwd_sel_o=0 and stall_o=0 regardless of inputs.
REQ-032 A reset asserted mid-stall SHALL drop stall_o to 0 asynchronously, and no in-flight entry SHALL survive reset.
REQ-033 After rst_i deasserts, the first rising edge SHALL capture the ID instruction normally.

Structure
REQ-034 Package fwd_pkg SHALL hold the stage-entry struct typedef, the constant SEL_NONE=0, and the function for the select encoding of DEPTH+1-k.
REQ-035 A sub-module fwd_match SHALL implement one source's priority compare over stages 2..DEPTH and be instantiated NUM_SRC times.

Verification
REQ-036 Defaults; issue add r3 then sub using r3 back-to-back -> the next cycle fwd_sel for source 0 of sub = 2.
REQ-037 Issue add r3, nop, then or r3 -> or in EX gives fwd_sel = 1.
REQ-038 Writers to r3 in both MEM and WB -> fwd_sel = 2 (youngest wins).
REQ-039 Issue lw r5, then add r6,r5 -> stall_o=1 for exactly 1 cycle, stage 1 gets a bubble, then add in EX gives fwd_sel = 1, and stall_cnt_o = 1.
REQ-040 With DEPTH=5, LOAD_STAGE=4, issue a load followed by a dependent instruction -> stall_o high for 2 cycles.
REQ-041 A source of r0 with a writer to r0 -> fwd_sel = 0; a flush during a load-use stall -> stall_o = 0 that cycle; rst_i low mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared types and helpers for the forwarding scoreboard.
package fwd_pkg;
  // Storage is sized for the widest supported build. Narrower builds
  // zero-extend into it, so every compare can run at full width.
  localparam int MAX_REG_W = 8;
  localparam int MAX_SRC   = 4;

  // Select value meaning "use the register-file operand"
  localparam int SEL_NONE = 0;

  typedef struct packed {
    logic                               valid;
    logic                               rw;
    logic                               load;
    logic [MAX_REG_W-1:0]               rd;
    logic [MAX_SRC-1:0][MAX_REG_W-1:0]  rs;
  } stage_t;

  // The oldest stage gets select 1 and younger stages get larger values,
  // so the mux encoding is independent of where EX sits.
  function automatic int sel_enc(input int depth, input int k);
    return depth + 1 - k;
  endfunction
endpackage

// File: rtl/fwd_match.sv
// Priority compare of one stage-1 source against stages 2..DEPTH.
module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = 2
) (
  input  logic                                 i_en,
  input  logic [MAX_REG_W-1:0]                 i_src,
  // bit j describes stage j+2; a set bit already implies valid, rw, rd!=0
  input  logic [DEPTH-2:0]                     i_prod,
  input  logic [DEPTH-2:0][MAX_REG_W-1:0]      i_rd,
  output logic [SEL_W-1:0]                     o_sel
);
  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    o_sel = SEL_W'(SEL_NONE);
    for (int j = DEPTH - 2; j >= 0; j--) begin
      if (i_en && i_prod[j] && (i_rd[j] == i_src))
        o_sel = SEL_W'(sel_enc(DEPTH, j + 2));
    end
  end
endmodule

// File: rtl/fwd_scoreboard.sv
// Pipeline scoreboard: tracks in-flight writers, selects forwarding
// sources for the EX instruction and raises load-use stalls for ID.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_W      = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 3,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      id_valid_i,
  input  logic [NUM_SRC*REG_W-1:0]  id_rs_i,
  input  logic [REG_W-1:0]          id_rd_i,
  input  logic                      id_rw_i,
  input  logic                      id_load_i,
  input  logic                      flush_i,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o,
  output logic                      stall_o,
  output logic [15:0]               stall_cnt_o
);
  stage_t                              r_stg [1:DEPTH];
  logic [15:0]                         r_cnt;
  stage_t                              w_nxt;
  logic [MAX_SRC-1:0][MAX_REG_W-1:0]   w_src;
  logic                                w_hz;
  logic [DEPTH-2:0]                    w_prod;
  logic [DEPTH-2:0][MAX_REG_W-1:0]     w_rd;
  logic [NUM_SRC-1:0][SEL_W-1:0]       w_sel;

  // Zero-extend the ID source addresses into full-width slots.
  always_comb begin
    w_src = '0;
    for (int s = 0; s < NUM_SRC; s++)
      w_src[s] = MAX_REG_W'(id_rs_i[s*REG_W +: REG_W]);
  end

  // Load-use hazard: a load still too young to forward its data.
  // With LOAD_STAGE=2 the loop is empty and the stall tie-off is 0.
  always_comb begin
    w_hz = 1'b0;
    for (int k = 1; k <= LOAD_STAGE - 2; k++)
      for (int s = 0; s < NUM_SRC; s++)
        if (r_stg[k].valid && r_stg[k].rw && r_stg[k].load &&
            (r_stg[k].rd != '0) && (r_stg[k].rd == w_src[s]))
          w_hz = 1'b1;
    stall_o = id_valid_i & ~flush_i & w_hz;
  end

  // Next stage-1 entry; stall and flush both inject a bubble.
  always_comb begin
    w_nxt       = '0;
    w_nxt.valid = id_valid_i & ~stall_o & ~flush_i;
    w_nxt.rw    = id_rw_i;
    w_nxt.load  = id_load_i;
    w_nxt.rd    = MAX_REG_W'(id_rd_i);
    w_nxt.rs    = w_src;
  end

  // Stage shift register; the WB entry simply falls off the end.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 1; k <= DEPTH; k++) r_stg[k] <= '0;
    end else begin
      r_stg[1] <= w_nxt;
      for (int k = 2; k <= DEPTH; k++) r_stg[k] <= r_stg[k-1];
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)                          r_cnt <= '0;
    else if (stall_o && r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
  end

  assign stall_cnt_o = r_cnt;

  // Writer summary for stages 2..DEPTH, shared by all source matchers.
  always_comb begin
    for (int j = 0; j <= DEPTH - 2; j++) begin
      w_prod[j] = r_stg[j+2].valid & r_stg[j+2].rw & (r_stg[j+2].rd != '0);
      w_rd[j]   = r_stg[j+2].rd;
    end
  end

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_match #(.DEPTH(DEPTH), .SEL_W(SEL_W)) u_match (
      .i_en   (r_stg[1].valid),
      .i_src  (r_stg[1].rs[s]),
      .i_prod (w_prod),
      .i_rd   (w_rd),
      .o_sel  (w_sel[s])
    );
  end

  assign fwd_sel_o = w_sel;
endmodule
